// File: rtl/sdrc_app_dbuf_pkg.sv
// Shared constants for the SDRAM application data buffer: default FIFO sizes
// and the write-burst tracking state encoding.
package sdrc_app_dbuf_pkg;

    localparam int WF_AW_DEF = 3;
    localparam int RF_AW_DEF = 3;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_BURST = 1'b1
    } wr_state_e;

endpackage

// File: rtl/sdrc_app_dbuf_if.sv
// Host and SDRAM-app side signals of the data buffer; the buffer is the slave,
// the host/width-converter environment is the master.
interface sdrc_app_dbuf_if #(
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int WF_AW  = 3,
    parameter int RF_AW  = 3
);
    logic              h_wr_valid;
    logic              h_wr_ready;
    logic [APP_DW-1:0] h_wr_data;
    logic [APP_BW-1:0] h_wr_be;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic              app_wr_next;
    logic              app_last_wr;
    logic [APP_DW-1:0] app_rd_data;
    logic              app_rd_valid;
    logic              app_last_rd;
    logic              h_rd_valid;
    logic              h_rd_ready;
    logic [APP_DW-1:0] h_rd_data;
    logic              h_rd_last;
    logic [WF_AW:0]    wr_level;
    logic [RF_AW:0]    rd_level;
    logic [7:0]        wr_beat_cnt;
    logic              wr_underrun;
    logic              rd_overflow;
    logic              clr_err;

    modport slave (
        input  h_wr_valid, h_wr_data, h_wr_be, app_wr_next, app_last_wr,
               app_rd_data, app_rd_valid, app_last_rd, h_rd_ready, clr_err,
        output h_wr_ready, app_wr_data, app_wr_en_n, h_rd_valid, h_rd_data,
               h_rd_last, wr_level, rd_level, wr_beat_cnt, wr_underrun, rd_overflow
    );

    modport master (
        output h_wr_valid, h_wr_data, h_wr_be, app_wr_next, app_last_wr,
               app_rd_data, app_rd_valid, app_last_rd, h_rd_ready, clr_err,
        input  h_wr_ready, app_wr_data, app_wr_en_n, h_rd_valid, h_rd_data,
               h_rd_last, wr_level, rd_level, wr_beat_cnt, wr_underrun, rd_overflow
    );

endinterface

// File: rtl/sdrc_app_dbuf_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers; the head
// reads as zero while empty so downstream sees a neutral word.
module sdrc_app_dbuf_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/sdrc_app_dbuf.sv
// Application-side data buffer: host write FIFO feeding the SDRAM width
// converter, read FIFO returning burst data to the host, burst-beat tracking.
module sdrc_app_dbuf
    import sdrc_app_dbuf_pkg::*;
#(
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int WF_AW  = WF_AW_DEF,
    parameter int RF_AW  = RF_AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    sdrc_app_dbuf_if.slave bus
);

    logic [APP_DW+APP_BW-1:0] wf_head;
    logic                     wf_full, wf_empty, wf_push, wf_pop;
    logic [WF_AW:0]           wf_level;
    logic [APP_DW:0]          rf_head;
    logic                     rf_full, rf_empty, rf_push, rf_pop;
    logic [RF_AW:0]           rf_level;

    wr_state_e  state_q;
    logic [7:0] beat_q;
    logic       underrun_q, underrun_d, underrun_evt;
    logic       overflow_q, overflow_d, overflow_evt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign wf_push      = bus.h_wr_valid & ~wf_full;
    assign wf_pop       = bus.app_wr_next & ~wf_empty;
    assign underrun_evt = bus.app_wr_next & wf_empty;

    assign rf_pop       = ~rf_empty & bus.h_rd_ready;
    assign rf_push      = bus.app_rd_valid & (~rf_full | rf_pop);
    assign overflow_evt = bus.app_rd_valid & rf_full & ~rf_pop;

    sdrc_app_dbuf_sync_fifo #(
        .DW (APP_DW + APP_BW),
        .AW (WF_AW)
    ) u_wr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (wf_push),
        .pop_i     (wf_pop),
        .wr_data_i ({bus.h_wr_be, bus.h_wr_data}),
        .rd_data_o (wf_head),
        .full_o    (wf_full),
        .empty_o   (wf_empty),
        .level_o   (wf_level)
    );

    sdrc_app_dbuf_sync_fifo #(
        .DW (APP_DW + 1),
        .AW (RF_AW)
    ) u_rd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (rf_push),
        .pop_i     (rf_pop),
        .wr_data_i ({bus.app_last_rd, bus.app_rd_data}),
        .rd_data_o (rf_head),
        .full_o    (rf_full),
        .empty_o   (rf_empty),
        .level_o   (rf_level)
    );

    // An empty write FIFO reads as zero, which inverts to a fully masked write.
    assign bus.app_wr_data = wf_head[APP_DW-1:0];
    assign bus.app_wr_en_n = ~wf_head[APP_DW +: APP_BW];
    assign bus.h_wr_ready  = ~wf_full;
    assign bus.wr_level    = wf_level;

    assign bus.h_rd_valid  = ~rf_empty;
    assign bus.h_rd_data   = rf_head[APP_DW-1:0];
    assign bus.h_rd_last   = rf_head[APP_DW];
    assign bus.rd_level    = rf_level;

    assign bus.wr_beat_cnt = beat_q;
    assign bus.wr_underrun = underrun_q;
    assign bus.rd_overflow = overflow_q;

    // A fresh error in the clearing cycle keeps the flag set.
    assign underrun_d = (underrun_q & ~bus.clr_err) | underrun_evt;
    assign overflow_d = (overflow_q & ~bus.clr_err) | overflow_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WR_IDLE;
            beat_q  <= 8'd0;
        end else begin
            unique case (state_q)
                WR_IDLE: begin
                    if (bus.app_wr_next) begin
                        beat_q <= 8'd1;
                        if (!bus.app_last_wr) begin
                            state_q <= WR_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.app_wr_next) begin
                        beat_q <= sat_inc8(beat_q);
                    end
                    if (bus.app_last_wr) begin
                        state_q <= WR_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_sdrc_app_dbuf.sv
// Directed bench for sdrc_app_dbuf: expected stream words are queued when
// stimulus is issued and compared by monitors at each DUT handshake.
module tb_sdrc_app_dbuf;

    logic clk;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    logic [35:0] wq[$];
    logic [32:0] rq[$];

    sdrc_app_dbuf_if #(.APP_DW(32), .APP_BW(4), .WF_AW(3), .RF_AW(3)) bus ();

    sdrc_app_dbuf #(.APP_DW(32), .APP_BW(4), .WF_AW(3), .RF_AW(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Write-side monitor: every app_wr_next consumes the head; an empty model
    // queue means a masked (underrun) word is expected.
    always @(negedge clk) begin
        logic [35:0] exp_w;
        logic [32:0] exp_r;
        if (reset_n && bus.app_wr_next) begin
            if (wq.size() == 0) exp_w = {4'hF, 32'h0};
            else exp_w = wq.pop_front();
            chk("wr_head", 64'({bus.app_wr_en_n, bus.app_wr_data}), 64'(exp_w));
        end
        if (reset_n && bus.h_rd_valid && bus.h_rd_ready) begin
            if (rq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_pop_unexpected actual=%0h required=none",
                         {bus.h_rd_last, bus.h_rd_data});
            end else begin
                exp_r = rq.pop_front();
                chk("rd_head", 64'({bus.h_rd_last, bus.h_rd_data}), 64'(exp_r));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.h_wr_valid   = 1'b0;
        bus.h_wr_data    = 32'h0;
        bus.h_wr_be      = 4'h0;
        bus.app_wr_next  = 1'b0;
        bus.app_last_wr  = 1'b0;
        bus.app_rd_data  = 32'h0;
        bus.app_rd_valid = 1'b0;
        bus.app_last_rd  = 1'b0;
        bus.h_rd_ready   = 1'b0;
        bus.clr_err      = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;

        // Reset state
        chk("rst_h_wr_ready", 64'(bus.h_wr_ready), 64'd1);
        chk("rst_h_rd_valid", 64'(bus.h_rd_valid), 64'd0);
        chk("rst_h_rd_data", 64'(bus.h_rd_data), 64'd0);
        chk("rst_h_rd_last", 64'(bus.h_rd_last), 64'd0);
        chk("rst_app_wr_data", 64'(bus.app_wr_data), 64'd0);
        chk("rst_app_wr_en_n", 64'(bus.app_wr_en_n), 64'hF);
        chk("rst_wr_level", 64'(bus.wr_level), 64'd0);
        chk("rst_rd_level", 64'(bus.rd_level), 64'd0);
        chk("rst_beat_cnt", 64'(bus.wr_beat_cnt), 64'd0);
        chk("rst_errors", 64'({bus.wr_underrun, bus.rd_overflow}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // 4-beat write burst
        for (int i = 0; i < 4; i++) begin
            bus.h_wr_valid = 1'b1;
            bus.h_wr_data  = 32'h11111111 * (i + 1);
            bus.h_wr_be    = 4'hF;
            cyc();
            wq.push_back({4'h0, 32'h11111111 * (i + 1)});
        end
        bus.h_wr_valid = 1'b0;
        chk("t1_wr_level4", 64'(bus.wr_level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            bus.app_wr_next = 1'b1;
            bus.app_last_wr = (i == 3);
            cyc();
        end
        bus.app_wr_next = 1'b0;
        bus.app_last_wr = 1'b0;
        chk("t1_beat_cnt", 64'(bus.wr_beat_cnt), 64'd4);
        chk("t1_wr_level0", 64'(bus.wr_level), 64'd0);
        chk("t1_en_n_empty", 64'(bus.app_wr_en_n), 64'hF);

        // Write FIFO full, blocked push, push+pop at level 7
        for (int i = 0; i < 8; i++) begin
            bus.h_wr_valid = 1'b1;
            bus.h_wr_data  = 32'hB0 + i;
            bus.h_wr_be    = (i % 2 == 0) ? 4'h5 : 4'hA;
            cyc();
            wq.push_back({((i % 2 == 0) ? 4'hA : 4'h5), 32'hB0 + i});
        end
        chk("t2_wr_ready_full", 64'(bus.h_wr_ready), 64'd0);
        chk("t2_wr_level8", 64'(bus.wr_level), 64'd8);
        bus.h_wr_data = 32'hDEAD;
        cyc();
        bus.h_wr_valid = 1'b0;
        chk("t2_blocked_level", 64'(bus.wr_level), 64'd8);
        bus.app_wr_next = 1'b1;
        cyc();
        bus.app_wr_next = 1'b0;
        chk("t2_new_burst_cnt", 64'(bus.wr_beat_cnt), 64'd1);
        chk("t2_wr_level7", 64'(bus.wr_level), 64'd7);
        bus.h_wr_valid  = 1'b1;
        bus.h_wr_data   = 32'hC8;
        bus.h_wr_be     = 4'hF;
        bus.app_wr_next = 1'b1;
        cyc();
        wq.push_back({4'h0, 32'hC8});
        bus.h_wr_valid  = 1'b0;
        bus.app_wr_next = 1'b0;
        chk("t2_pushpop_level", 64'(bus.wr_level), 64'd7);
        chk("t2_pushpop_cnt", 64'(bus.wr_beat_cnt), 64'd2);
        for (int i = 0; i < 7; i++) begin
            bus.app_wr_next = 1'b1;
            bus.app_last_wr = (i == 6);
            cyc();
        end
        bus.app_wr_next = 1'b0;
        bus.app_last_wr = 1'b0;
        chk("t2_drain_cnt", 64'(bus.wr_beat_cnt), 64'd9);
        chk("t2_drain_level", 64'(bus.wr_level), 64'd0);

        // Underrun and sticky-error clearing
        bus.app_wr_next = 1'b1;
        cyc();
        bus.app_wr_next = 1'b0;
        chk("t3_underrun_set", 64'(bus.wr_underrun), 64'd1);
        chk("t3_underrun_cnt", 64'(bus.wr_beat_cnt), 64'd1);
        chk("t3_underrun_level", 64'(bus.wr_level), 64'd0);
        bus.clr_err = 1'b1;
        cyc();
        bus.clr_err = 1'b0;
        chk("t3_clr", 64'(bus.wr_underrun), 64'd0);
        bus.clr_err     = 1'b1;
        bus.app_wr_next = 1'b1;
        cyc();
        bus.clr_err     = 1'b0;
        bus.app_wr_next = 1'b0;
        chk("t3_clr_vs_new", 64'(bus.wr_underrun), 64'd1);
        bus.clr_err     = 1'b1;
        bus.app_last_wr = 1'b1;
        cyc();
        bus.clr_err     = 1'b0;
        bus.app_last_wr = 1'b0;
        chk("t3_clr2", 64'(bus.wr_underrun), 64'd0);
        bus.h_wr_valid  = 1'b1;
        bus.h_wr_data   = 32'hE1;
        bus.h_wr_be     = 4'h3;
        bus.app_wr_next = 1'b1;
        cyc();
        wq.push_back({4'hC, 32'hE1});
        bus.h_wr_valid  = 1'b0;
        bus.app_wr_next = 1'b0;
        chk("t3_push_underrun", 64'(bus.wr_underrun), 64'd1);
        chk("t3_push_kept", 64'(bus.wr_level), 64'd1);
        bus.clr_err     = 1'b1;
        bus.app_wr_next = 1'b1;
        bus.app_last_wr = 1'b1;
        cyc();
        bus.clr_err     = 1'b0;
        bus.app_wr_next = 1'b0;
        bus.app_last_wr = 1'b0;
        chk("t3_pop_cnt", 64'(bus.wr_beat_cnt), 64'd2);
        chk("t3_pop_level", 64'(bus.wr_level), 64'd0);
        chk("t3_no_err", 64'(bus.wr_underrun), 64'd0);

        // Read FIFO fill, overflow, full push+pop, drain
        for (int i = 0; i < 8; i++) begin
            bus.app_rd_valid = 1'b1;
            bus.app_rd_data  = 32'hA0 + i;
            bus.app_last_rd  = (i == 7);
            cyc();
            rq.push_back({(i == 7), 32'hA0 + i});
        end
        chk("t4_rd_level8", 64'(bus.rd_level), 64'd8);
        chk("t4_no_ovf", 64'(bus.rd_overflow), 64'd0);
        chk("t4_rd_valid", 64'(bus.h_rd_valid), 64'd1);
        bus.app_rd_data = 32'hA8;
        bus.app_last_rd = 1'b0;
        cyc();
        bus.app_rd_valid = 1'b0;
        chk("t4_ovf_set", 64'(bus.rd_overflow), 64'd1);
        chk("t4_ovf_level", 64'(bus.rd_level), 64'd8);
        bus.clr_err = 1'b1;
        cyc();
        bus.clr_err = 1'b0;
        chk("t4_ovf_clr", 64'(bus.rd_overflow), 64'd0);
        bus.app_rd_valid = 1'b1;
        bus.app_rd_data  = 32'hA9;
        bus.app_last_rd  = 1'b1;
        bus.h_rd_ready   = 1'b1;
        cyc();
        rq.push_back({1'b1, 32'hA9});
        bus.app_rd_valid = 1'b0;
        bus.app_last_rd  = 1'b0;
        bus.h_rd_ready   = 1'b0;
        chk("t4_full_pushpop_ovf", 64'(bus.rd_overflow), 64'd0);
        chk("t4_full_pushpop_lvl", 64'(bus.rd_level), 64'd8);
        bus.h_rd_ready = 1'b1;
        repeat (8) cyc();
        bus.h_rd_ready = 1'b0;
        chk("t4_drain_valid", 64'(bus.h_rd_valid), 64'd0);
        chk("t4_drain_level", 64'(bus.rd_level), 64'd0);
        chk("t4_drain_data", 64'({bus.h_rd_last, bus.h_rd_data}), 64'd0);

        // Asynchronous reset mid-burst
        bus.app_wr_next = 1'b1;
        cyc();
        bus.app_wr_next = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.h_wr_valid   = 1'b1;
            bus.h_wr_data    = 32'hF0 + i;
            bus.h_wr_be      = 4'hF;
            bus.app_rd_valid = 1'b1;
            bus.app_rd_data  = 32'h50 + i;
            cyc();
            wq.push_back({4'h0, 32'hF0 + i});
            rq.push_back({1'b0, 32'h50 + i});
        end
        bus.h_wr_valid   = 1'b0;
        bus.app_rd_valid = 1'b0;
        bus.app_wr_next  = 1'b1;
        cyc();
        bus.app_wr_next  = 1'b0;
        chk("t5_pre_underrun", 64'(bus.wr_underrun), 64'd1);
        chk("t5_pre_cnt", 64'(bus.wr_beat_cnt), 64'd2);
        chk("t5_pre_wr_level", 64'(bus.wr_level), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        wq.delete();
        rq.delete();
        chk("t5_wr_level", 64'(bus.wr_level), 64'd0);
        chk("t5_rd_level", 64'(bus.rd_level), 64'd0);
        chk("t5_en_n", 64'(bus.app_wr_en_n), 64'hF);
        chk("t5_rd_valid", 64'(bus.h_rd_valid), 64'd0);
        chk("t5_errors", 64'({bus.wr_underrun, bus.rd_overflow}), 64'd0);
        chk("t5_cnt", 64'(bus.wr_beat_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk("t5_post_ready", 64'(bus.h_wr_ready), 64'd1);

        chk("end_wq_empty", 64'(wq.size()), 64'd0);
        chk("end_rq_empty", 64'(rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
